// File: rtl/neopixel_pkg.sv
// rtl/neopixel_pkg.sv - shared types and default constants for the WS2812 chain driver
//
// Contents:
//   state_t         frame FSM states (IDLE, LOAD, HIGH, LOW, LATCH)
//   ADDR_SHOW       register address that requests a frame
//   BITS_PER_PIXEL  GRB colour width shifted out per pixel
//   DEF_*           default chain length and timing in ctrl_clock cycles (100 MHz)
package neopixel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HIGH,
    ST_LOW,
    ST_LATCH
  } state_t;

  localparam logic [7:0] ADDR_SHOW      = 8'hFF;
  localparam int         BITS_PER_PIXEL = 24;

  localparam int DEF_PIXELS = 12;
  localparam int DEF_T0H    = 40;
  localparam int DEF_T1H    = 80;
  localparam int DEF_TBIT   = 125;
  localparam int DEF_TRESET = 6000;

endpackage

// File: rtl/neopixel_bit_serializer.sv
// rtl/neopixel_bit_serializer.sv - per-bit WS2812 timing: shifter, cycle counter, bit counter
//
// Ports:
//   ctrl_clock, ctrl_reset_n  clock, asynchronous active-low reset
//   load                      copy pixel into the shifter and restart bit/cycle counting
//   pixel[23:0]               GRB colour, MSB sent first
//   in_high, in_low           frame FSM is in HIGH / LOW
//   high_end                  last cycle of the high phase of the current bit
//   low_end                   last cycle of the low phase of the current bit
//   last_bit                  current bit is the final (LSB) bit of the pixel
module neopixel_bit_serializer
  import neopixel_pkg::*;
#(
  parameter int C_T0H  = DEF_T0H,
  parameter int C_T1H  = DEF_T1H,
  parameter int C_TBIT = DEF_TBIT
) (
  input  logic        ctrl_clock,
  input  logic        ctrl_reset_n,
  input  logic        load,
  input  logic [23:0] pixel,
  input  logic        in_high,
  input  logic        in_low,
  output logic        high_end,
  output logic        low_end,
  output logic        last_bit
);

  localparam int CYC_W = $clog2(C_TBIT);
  localparam int BIT_W = $clog2(BITS_PER_PIXEL);

  localparam logic [CYC_W-1:0] T0H_LAST  = CYC_W'(C_T0H - 1);
  localparam logic [CYC_W-1:0] T1H_LAST  = CYC_W'(C_T1H - 1);
  localparam logic [CYC_W-1:0] TBIT_LAST = CYC_W'(C_TBIT - 1);
  // The final bit of a pixel ends its LOW one cycle early: the following
  // LOAD (or first LATCH) cycle supplies the last low cycle of the period.
  localparam logic [CYC_W-1:0] TBIT_EARLY = CYC_W'(C_TBIT - 2);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(BITS_PER_PIXEL - 1);

  logic [23:0]      shifter;
  logic [CYC_W-1:0] cyc_cnt;
  logic [BIT_W-1:0] bit_cnt;

  // cyc_cnt runs across the whole bit period, so LOW ends on an absolute count.
  assign last_bit = (bit_cnt == BIT_LAST);
  assign high_end = in_high && (cyc_cnt == (shifter[23] ? T1H_LAST : T0H_LAST));
  assign low_end  = in_low && (cyc_cnt == (last_bit ? TBIT_EARLY : TBIT_LAST));

  always_ff @(posedge ctrl_clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      shifter <= '0;
      cyc_cnt <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shifter <= pixel;
      cyc_cnt <= '0;
      bit_cnt <= '0;
    end else if (low_end) begin
      cyc_cnt <= '0;
      if (!last_bit) begin
        shifter <= {shifter[22:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end else if (in_high || in_low) begin
      cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/neopixel_driver.sv
// rtl/neopixel_driver.sv - WS2812 chain driver: pixel buffer, register decode, frame FSM
//
// Optional feature: define NEOPIXEL_AUTO_REFRESH_EN to resend the frame forever
// after the first SHOW (ctrl_ready then never returns high).
//
// Ports:
//   ctrl_clock, ctrl_reset_n  clock, asynchronous active-low reset
//   ctrl_write_en             single-cycle write strobe
//   ctrl_address[31:0]        [7:0] decoded, [31:8] must be zero; 8'hFF = SHOW
//   ctrl_write_data[31:0]     pixel colour in [23:0] (GRB)
//   ctrl_read_data[31:0]      registered readback, 1-cycle latency
//   ctrl_ready                no frame transmitting, latching or pending
//   neopixel_out              serial data line
module neopixel_driver
  import neopixel_pkg::*;
#(
  parameter int C_PIXELS = DEF_PIXELS,
  parameter int C_T0H    = DEF_T0H,
  parameter int C_T1H    = DEF_T1H,
  parameter int C_TBIT   = DEF_TBIT,
  parameter int C_TRESET = DEF_TRESET
) (
  input  logic        ctrl_clock,
  input  logic        ctrl_reset_n,
  input  logic        ctrl_write_en,
  input  logic [31:0] ctrl_address,
  input  logic [31:0] ctrl_write_data,
  output logic [31:0] ctrl_read_data,
  output logic        ctrl_ready,
  output logic        neopixel_out
);

  localparam int PIX_W = (C_PIXELS > 1) ? $clog2(C_PIXELS) : 1;
  localparam int LAT_W = (C_TRESET > 1) ? $clog2(C_TRESET) : 1;

  localparam logic [7:0]       PIX_LIMIT = 8'(C_PIXELS);
  localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(C_PIXELS - 1);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(C_TRESET - 1);

  logic [23:0]      pixel_buf [C_PIXELS];
  state_t           state;
  logic             pending;
  logic [PIX_W-1:0] pix_idx;
  logic [LAT_W-1:0] lat_cnt;

  logic [7:0]  addr_lo;
  logic        addr_ok;
  logic        pix_hit;
  logic        show_hit;
  logic [23:0] rd_pix;
  logic [23:0] load_pix;
  logic        high_end;
  logic        low_end;
  logic        last_bit;
  logic        unused_wdata;

  assign addr_lo      = ctrl_address[7:0];
  assign addr_ok      = (ctrl_address[31:8] == 24'd0);
  assign pix_hit      = ctrl_write_en && addr_ok && (addr_lo < PIX_LIMIT);
  assign show_hit     = ctrl_write_en && addr_ok && (addr_lo == ADDR_SHOW);
  assign unused_wdata = &{1'b0, ctrl_write_data[31:24]};

  always_ff @(posedge ctrl_clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < C_PIXELS; i++) pixel_buf[i] <= '0;
    end else begin
      for (int i = 0; i < C_PIXELS; i++)
        if (pix_hit && (addr_lo == 8'(i))) pixel_buf[i] <= ctrl_write_data[23:0];
    end
  end

  // Explicit compare-muxes keep out-of-range indices harmless for any C_PIXELS.
  always_comb begin
    rd_pix   = '0;
    load_pix = '0;
    for (int i = 0; i < C_PIXELS; i++) begin
      if (addr_lo == 8'(i))       rd_pix   = pixel_buf[i];
      if (pix_idx == PIX_W'(i))   load_pix = pixel_buf[i];
    end
  end

  always_ff @(posedge ctrl_clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      ctrl_read_data <= '0;
    end else if (addr_ok && (addr_lo < PIX_LIMIT)) begin
      ctrl_read_data <= {8'h00, rd_pix};
    end else if (addr_ok && (addr_lo == ADDR_SHOW)) begin
      ctrl_read_data <= {31'b0, ~ctrl_ready};
    end else begin
      ctrl_read_data <= '0;
    end
  end

  neopixel_bit_serializer #(
    .C_T0H  (C_T0H),
    .C_T1H  (C_T1H),
    .C_TBIT (C_TBIT)
  ) u_serializer (
    .ctrl_clock   (ctrl_clock),
    .ctrl_reset_n (ctrl_reset_n),
    .load         (state == ST_LOAD),
    .pixel        (load_pix),
    .in_high      (state == ST_HIGH),
    .in_low       (state == ST_LOW),
    .high_end     (high_end),
    .low_end      (low_end),
    .last_bit     (last_bit)
  );

  // The first LATCH cycle is the tail of the final bit period, so the low gap
  // seen between the last bit and the next frame's first HIGH is C_TRESET.
  always_ff @(posedge ctrl_clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state        <= ST_IDLE;
      pending      <= 1'b0;
      pix_idx      <= '0;
      lat_cnt      <= '0;
      ctrl_ready   <= 1'b1;
      neopixel_out <= 1'b0;
    end else begin
      if (show_hit && (state != ST_IDLE)) pending <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (show_hit) begin
            state      <= ST_LOAD;
            pix_idx    <= '0;
            ctrl_ready <= 1'b0;
          end
        end
        ST_LOAD: begin
          state        <= ST_HIGH;
          neopixel_out <= 1'b1;
        end
        ST_HIGH: begin
          if (high_end) begin
            state        <= ST_LOW;
            neopixel_out <= 1'b0;
          end
        end
        ST_LOW: begin
          if (low_end) begin
            if (!last_bit) begin
              state        <= ST_HIGH;
              neopixel_out <= 1'b1;
            end else if (pix_idx != PIX_LAST) begin
              state   <= ST_LOAD;
              pix_idx <= pix_idx + 1'b1;
            end else begin
              state   <= ST_LATCH;
              lat_cnt <= '0;
            end
          end
        end
        ST_LATCH: begin
          if (lat_cnt == LAT_LAST) begin
`ifdef NEOPIXEL_AUTO_REFRESH_EN
            state   <= ST_LOAD;
            pix_idx <= '0;
            pending <= 1'b0;
`else
            // A SHOW landing on this very cycle counts as pending.
            if (pending || show_hit) begin
              state   <= ST_LOAD;
              pix_idx <= '0;
              pending <= 1'b0;
            end else begin
              state      <= ST_IDLE;
              ctrl_ready <= 1'b1;
            end
`endif
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        default: begin
          state        <= ST_IDLE;
          neopixel_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neopixel_driver.sv
// tb/tb_neopixel_driver.sv - directed self-checking bench for neopixel_driver
module tb_neopixel_driver;

  localparam int FRAME_CYC = 626;  // LOAD + 48 bit periods + latch, minus overlap

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rd;
  logic        ready;
  logic        out;

  int checks = 0;
  int failures = 0;

  logic        wave [2048];
  logic        rdy  [2048];
  logic [31:0] rdd  [2048];

  always #5 clk = ~clk;

  neopixel_driver #(
    .C_PIXELS (2),
    .C_T0H    (4),
    .C_T1H    (8),
    .C_TBIT   (12),
    .C_TRESET (50)
  ) dut (
    .ctrl_clock      (clk),
    .ctrl_reset_n    (rst_n),
    .ctrl_write_en   (we),
    .ctrl_address    (addr),
    .ctrl_write_data (wdata),
    .ctrl_read_data  (rd),
    .ctrl_ready      (ready),
    .neopixel_out    (out)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
    @(negedge clk);
    addr = a;
    we   = 1'b0;
    @(negedge clk);
    v = rd;
  endtask

  // Index 0 is the negedge right after the SHOW edge (the LOAD cycle).
  task automatic capture(input int n, input int s2, input int s3);
    addr = 32'hFF;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      wave[i] = out;
      rdy[i]  = ready;
      rdd[i]  = rd;
      we      = (i == s2) || (i == s3);
    end
    we = 1'b0;
  endtask

  // Expected line level i cycles after the frame's LOAD cycle.
  function automatic logic exp_frame(input int i, input logic [23:0] p0, input logic [23:0] p1);
    int t, b;
    logic [23:0] px;
    logic bv;
    if (i < 1 || i > 576) return 1'b0;
    t  = i - 1;
    b  = t / 12;
    px = (b < 24) ? p0 : p1;
    bv = px[23 - (b % 24)];
    return (t % 12) < (bv ? 8 : 4);
  endfunction

  task automatic check_wave(input string tag, input int n, input int mode);
    int mism;
    logic e;
    mism = 0;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       e = exp_frame(i, 24'hFF0000, 24'h000001);
        1:       e = (i < FRAME_CYC) ? exp_frame(i, 24'hFF0000, 24'h000001)
                                     : exp_frame(i - FRAME_CYC, 24'hFF0000, 24'h000001);
        default: e = exp_frame(i % FRAME_CYC, 24'hFF0000, 24'h000001);
      endcase
      if (wave[i] !== e) mism++;
    end
    check_eq(tag, mism, 0);
  endtask

  function automatic int count_pulses(input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++)
      if (wave[i] && (i == 0 || !wave[i-1])) c++;
    return c;
  endfunction

  function automatic int count_busy(input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) if (!rdy[i]) c++;
    return c;
  endfunction

  initial begin
    logic [31:0] v;
    int k;
    int highs;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_out", out, 0);
    check_eq("reset_ready", ready, 1);
    check_eq("reset_rdata", rd, 0);
    rst_n = 1'b1;

    bus_write(32'h1, 32'h00ABCDEF);
    bus_read(32'h1, v);  check_eq("read_pix1", v, 32'h00ABCDEF);
    bus_read(32'h5, v);  check_eq("read_addr5", v, 0);
    bus_read(32'hFF, v); check_eq("read_show_idle", v, 0);

    bus_write(32'h2, 32'h00123456);
    bus_write(32'h100, 32'h00111111);
    bus_write(32'h1FF, 32'h0);
    check_eq("ignored_no_frame", ready, 1);
    bus_read(32'h0, v);  check_eq("ignored_pix0", v, 0);
    bus_read(32'h1, v);  check_eq("ignored_pix1", v, 32'h00ABCDEF);

    bus_write(32'h0, 32'h00FF0000);
    bus_write(32'h1, 32'h00000001);

`ifdef NEOPIXEL_AUTO_REFRESH_EN
    bus_write(32'hFF, 32'h0);
    capture(3 * FRAME_CYC, -1, -1);
    check_wave("auto_wave", 3 * FRAME_CYC, 2);
    check_eq("auto_pulses", count_pulses(3 * FRAME_CYC), 144);
    check_eq("auto_busy", count_busy(3 * FRAME_CYC), 3 * FRAME_CYC);
    check_eq("auto_gap_rise", wave[FRAME_CYC + 1], 1);
    check_eq("auto_read_busy", rdd[1000], 1);
`else
    bus_write(32'hFF, 32'h0);
    capture(640, -1, -1);
    check_wave("frame_wave", 640, 0);
    check_eq("frame_pulses", count_pulses(640), 48);
    check_eq("frame_busy", count_busy(640), FRAME_CYC);
    check_eq("frame_ready_back", rdy[FRAME_CYC], 1);
    check_eq("read_show_busy", rdd[300], 1);
    check_eq("read_show_done", rdd[639], 0);

    bus_write(32'hFF, 32'h0);
    capture(1300, 100, 200);
    check_wave("pend_wave", 1300, 1);
    check_eq("pend_pulses", count_pulses(1300), 96);
    check_eq("pend_gap_low", wave[FRAME_CYC], 0);
    check_eq("pend_restart", wave[FRAME_CYC + 1], 1);
    check_eq("pend_busy", count_busy(1300), 2 * FRAME_CYC);
    check_eq("pend_ready_back", rdy[2 * FRAME_CYC], 1);
`endif

    bus_write(32'hFF, 32'h0);
    k = 0;
    while (!out && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("rise_timeout", (k < 100), 1);
    check_eq("busy_before_reset", rd, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_out", out, 0);
    check_eq("async_ready", ready, 1);
    check_eq("async_rdata", rd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(32'h0, v);  check_eq("post_reset_pix0", v, 0);
    bus_read(32'h1, v);  check_eq("post_reset_pix1", v, 0);
    bus_read(32'hFF, v); check_eq("post_reset_show", v, 0);
    highs = 0;
    repeat (20) begin
      @(negedge clk);
      if (out) highs++;
    end
    check_eq("post_reset_quiet", highs, 0);
    check_eq("post_reset_ready", ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
